// File: rtl/rvc_asap_cr_mem_if.sv
// -----------------------------------------------------------------------------
// rvc_asap_cr_mem_if
// Core data-memory access bundle as seen by the control-register responder.
//   CrWrEn   : write strobe for the current access
//   CrRdEn   : read strobe for the current access
//   CrAddr   : byte address ([13:12] region, [11:2] word offset)
//   CrWrData : write data
//   CrByteEn : byte-lane enables for writes
//   CrRdData : registered read data, valid one cycle after CrRdEn
// Modports: master = core side, slave = responder side.
// -----------------------------------------------------------------------------
interface rvc_asap_cr_mem_if;
   logic        CrWrEn;
   logic        CrRdEn;
   logic [31:0] CrAddr;
   logic [31:0] CrWrData;
   logic [3:0]  CrByteEn;
   logic [31:0] CrRdData;

   modport master (
      output CrWrEn, CrRdEn, CrAddr, CrWrData, CrByteEn,
      input  CrRdData
   );

   modport slave (
      input  CrWrEn, CrRdEn, CrAddr, CrWrData, CrByteEn,
      output CrRdData
   );
endinterface

// File: rtl/rvc_asap_cr_mem.sv
// -----------------------------------------------------------------------------
// rvc_asap_cr_mem
// Control-register responder for the CR region (CrAddr[13:12] == 2'b10).
// Holds the RW board/VGA registers and returns synchronised, debounced board
// inputs on reads.
//   Clock, Rst          : core clock, synchronous active-high reset
//   cr (slave)          : data-memory access bundle (strobes, address, data)
//   Button_0, Button_1  : asynchronous push buttons
//   Switch[9:0]         : asynchronous slide switches
//   SEG7_0..SEG7_5      : seven-segment digit registers
//   LED[9:0]            : LED register
//   CursorH, CursorV    : VGA cursor position registers
// Word map (CrAddr[11:2]): 0..5 SEG7_0..5, 6 LED, 7 Button_0, 8 Button_1,
// 9 Switch, 10 CursorH, 11 CursorV. Offsets 7..9 are read-only.
// -----------------------------------------------------------------------------
module rvc_asap_cr_mem #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        Clock,
   input  logic        Rst,
   rvc_asap_cr_mem_if.slave cr,
   input  logic        Button_0,
   input  logic        Button_1,
   input  logic [9:0]  Switch,
   output logic [7:0]  SEG7_0,
   output logic [7:0]  SEG7_1,
   output logic [7:0]  SEG7_2,
   output logic [7:0]  SEG7_3,
   output logic [7:0]  SEG7_4,
   output logic [7:0]  SEG7_5,
   output logic [9:0]  LED,
   output logic [31:0] CursorH,
   output logic [31:0] CursorV
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = cur;
      for (int b = 0; b < 4; b++)
         if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
      return res;
   endfunction

   logic        hit;
   logic [9:0]  offset;
   logic [31:0] rd_sel;
   wire         unused_addr_bits = ^{cr.CrAddr[31:14], cr.CrAddr[1:0]};

   // Input bit order: {Switch[9:0], Button_1, Button_0}
   logic [11:0]      raw_in;
   logic [11:0]      sync_p0;
   logic [11:0]      sync_p1;
   logic [11:0]      deb;
   logic [CNT_W-1:0] cnt [12];

   assign hit    = (cr.CrAddr[13:12] == 2'b10);
   assign offset = cr.CrAddr[11:2];
   assign raw_in = {Switch, Button_1, Button_0};

   // Stage p0/p1: two-flop synchroniser, then per-bit debounce counters
   always_ff @(posedge Clock) begin
      if (Rst) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         deb     <= '0;
         for (int i = 0; i < 12; i++) cnt[i] <= '0;
      end else begin
         sync_p0 <= raw_in;
         sync_p1 <= sync_p0;
         for (int i = 0; i < 12; i++) begin
            if (sync_p1[i] == deb[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               deb[i] <= sync_p1[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Write path: register outputs come straight from these flops
   always_ff @(posedge Clock) begin
      if (Rst) begin
         SEG7_0  <= '0;
         SEG7_1  <= '0;
         SEG7_2  <= '0;
         SEG7_3  <= '0;
         SEG7_4  <= '0;
         SEG7_5  <= '0;
         LED     <= '0;
         CursorH <= '0;
         CursorV <= '0;
      end else if (cr.CrWrEn && hit) begin
         case (offset)
            10'd0: if (cr.CrByteEn[0]) SEG7_0 <= cr.CrWrData[7:0];
            10'd1: if (cr.CrByteEn[0]) SEG7_1 <= cr.CrWrData[7:0];
            10'd2: if (cr.CrByteEn[0]) SEG7_2 <= cr.CrWrData[7:0];
            10'd3: if (cr.CrByteEn[0]) SEG7_3 <= cr.CrWrData[7:0];
            10'd4: if (cr.CrByteEn[0]) SEG7_4 <= cr.CrWrData[7:0];
            10'd5: if (cr.CrByteEn[0]) SEG7_5 <= cr.CrWrData[7:0];
            10'd6: begin
               // Lane 1 only carries LED[9:8]
               if (cr.CrByteEn[0]) LED[7:0] <= cr.CrWrData[7:0];
               if (cr.CrByteEn[1]) LED[9:8] <= cr.CrWrData[9:8];
            end
            10'd10: CursorH <= merge_lanes(CursorH, cr.CrWrData, cr.CrByteEn);
            10'd11: CursorV <= merge_lanes(CursorV, cr.CrWrData, cr.CrByteEn);
            default: ;
         endcase
      end
   end

   always_comb begin
      rd_sel = '0;
      if (hit) begin
         case (offset)
            10'd0:   rd_sel = {24'd0, SEG7_0};
            10'd1:   rd_sel = {24'd0, SEG7_1};
            10'd2:   rd_sel = {24'd0, SEG7_2};
            10'd3:   rd_sel = {24'd0, SEG7_3};
            10'd4:   rd_sel = {24'd0, SEG7_4};
            10'd5:   rd_sel = {24'd0, SEG7_5};
            10'd6:   rd_sel = {22'd0, LED};
            10'd7:   rd_sel = {31'd0, deb[0]};
            10'd8:   rd_sel = {31'd0, deb[1]};
            10'd9:   rd_sel = {22'd0, deb[11:2]};
            10'd10:  rd_sel = CursorH;
            10'd11:  rd_sel = CursorV;
            default: rd_sel = '0;
         endcase
      end
   end

   // Read stage: samples pre-write register values, holds when idle
   always_ff @(posedge Clock) begin
      if (Rst)            cr.CrRdData <= '0;
      else if (cr.CrRdEn) cr.CrRdData <= rd_sel;
   end

endmodule

// File: doc/rvc_asap_cr_mem.md
Name: rvc_asap_cr_mem

Overview:
- Control-register responder on the core data-memory interface for the CR region (region bits [13:12] = 2'b10; offsets CR_SEG7_0 through CR_CURSOR_V).
- Holds the RW registers: seven-segment digits, LEDs and VGA cursor H/V. Drives them to board and VGA logic.
- Synchronises and debounces the asynchronous board inputs (2 buttons, 10 switches) and returns them on reads.
- Sits beside the D_MEM and VGA_MEM responders; the data-memory read mux selects its read data.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from its debounced value before that value updates (legal range 1..2^16).

Ports:
Clock  in  1  core clock
Rst  in  1  synchronous active-high reset
CrWrEn  in  1  write strobe for the current access
CrRdEn  in  1  read strobe for the current access
CrAddr  in  32  byte address; bits [13:12] region, bits [11:2] word offset, bits [1:0] ignored, bits [31:14] ignored
CrWrData  in  32  write data
CrByteEn  in  4  byte enables for writes
CrRdData  out  32  read data, one cycle after CrRdEn
Button_0  in  1  async push button
Button_1  in  1  async push button
Switch  in  10  async slide switches
SEG7_0..SEG7_5  out  8 each  digit registers
LED  out  10  LED register
CursorH  out  32  VGA cursor horizontal
CursorV  out  32  VGA cursor vertical

Behaviour:
- Hit = (CrAddr[13:12] == 2'b10). The register is selected by CrAddr[11:2]: 0x000 SEG7_0, 0x004 SEG7_1, 0x008 SEG7_2, 0x00C SEG7_3, 0x010 SEG7_4, 0x014 SEG7_5, 0x018 LED, 0x01C Button_0, 0x020 Button_1, 0x024 Switch, 0x028 CURSOR_H, 0x02C CURSOR_V.
- Write: on a rising edge with CrWrEn & hit & RW offset, update each byte lane whose CrByteEn bit is set.
  - Fields narrower than 32 bits take only their low bits: SEG7 takes byte 0; LED takes bits [9:0], with lane 1 supplying bits [9:8].
  - Writes to RO offsets (Button_0, Button_1, Switch), unmapped offsets or non-hit addresses are ignored.
- Read: registered, one-cycle latency. On the edge where CrRdEn is high, CrRdData is loaded with the selected value, zero-extended to 32 bits.
  - Non-hit or unmapped offset loads 0.
  - When CrRdEn is low, CrRdData holds its previous value.
- Simultaneous CrRdEn and CrWrEn to the same offset: CrRdData returns the pre-write value; the new value is visible from the next read.
- RW outputs are driven directly from the register flops, so a write is visible on the outputs the cycle after the write edge.
- Input path, applied per bit to all 12 RO bits:
  - 2-flop synchroniser feeds the debouncer.
  - Debouncer per bit: a counter increments each cycle the synchronised bit differs from the debounced bit, and clears whenever they match.
  - When the counter is at DEBOUNCE_CYCLES-1 and the bits still differ, the debounced bit takes the synchronised value and the counter clears.
  - A clean input change is readable 2+DEBOUNCE_CYCLES edges after it is applied.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes the debounced value.
- Reset: on a Rst edge, all RW registers, SEG7 and LED outputs, CursorH/V, CrRdData, synchroniser flops, debounced values and counters go to 0.
  - Rst dominates CrWrEn/CrRdEn in the same cycle.
  - Reset mid-debounce discards the partial count.
- Counter width is clog2(DEBOUNCE_CYCLES)+1; the counter never wraps.

Test Plan:
- Rst high 2 cycles -> all outputs 0. Then read 0x2018 -> CrRdData=0 one cycle after CrRdEn.
- Write 0x2018 data 0xFFFF_FFFF, ByteEn 4'b1111 -> LED=0x3FF next cycle. Read returns 0x0000_03FF. Then write ByteEn 4'b0001 data 0x0 -> LED=0x300.
- Write 0x202C data 0x1234_5678 ByteEn 4'b0101 from reset -> CursorV=0x0034_0078. Same-cycle read+write 0x202C data 0xFFFF_FFFF -> read returns 0x0034_0078, next read 0xFFFF_FFFF.
- Switch=0x2A5 held steady, DEBOUNCE_CYCLES=16 -> read 0x2024 before edge 18 returns 0. Read issued after edge 18 returns 0x0000_02A5.
- Button_0 pulsed high for 5 cycles -> read 0x201C stays 0 throughout. Held high 20 cycles -> reads 1.
- Write 0x1018 (D_MEM region) and 0x201C (RO) and 0x2030 (unmapped) -> no output changes. Reads of 0x1018 and 0x2030 return 0.
